// File: rtl/tug_referee_if.sv
// Pin bundle between the tug-of-war referee and its push/tick sources and display sinks.
interface tug_referee_if;
    logic       lpush;
    logic       rpush;
    logic       slowen;
    logic [6:0] rope_led;
    logic [6:0] score;
    logic       isVictory;
    logic       winner;

    modport master (
        output lpush, rpush, slowen,
        input  rope_led, score, isVictory, winner
    );

    modport slave (
        input  lpush, rpush, slowen,
        output rope_led, score, isVictory, winner
    );
endinterface

// File: rtl/tug_referee.sv
// Tug-of-war referee: rope position, round scoring, timed round hold and game-over latch.
// Optional macro FALSE_START_EN: pushes during a hold penalise the pusher at the next restart.
module tug_referee #(
    parameter int WIN_ROUNDS = 3,
    parameter int ROUND_HOLD = 4
) (
    input logic          clk,
    input logic          rst,
    tug_referee_if.slave bus
);

    typedef enum logic [1:0] {PLAY, HOLD, OVER} state_t;

    localparam logic [1:0] WIN_C  = WIN_ROUNDS[1:0];
    localparam logic [3:0] HOLD_C = ROUND_HOLD[3:0];

    state_t     r_state, w_state_next;
    logic [2:0] r_pos, w_pos_next, w_restart_pos;
    logic [1:0] r_lcount, r_rcount, w_lcount_next, w_rcount_next;
    logic [3:0] r_hold, w_hold_next;
    logic [6:0] r_rope_led, r_score, w_rope_led, w_score;
    logic       r_victory, r_winner, w_victory, w_winner;

    function automatic logic [1:0] sat_inc(input logic [1:0] cnt);
        return (cnt == WIN_C) ? cnt : cnt + 2'd1;
    endfunction

    function automatic logic [2:0] therm(input logic [1:0] cnt);
        case (cnt)
            2'd0:    return 3'b000;
            2'd1:    return 3'b001;
            2'd2:    return 3'b011;
            default: return 3'b111;
        endcase
    endfunction

`ifdef FALSE_START_EN
    logic r_lpen, r_rpen, w_lpen_next, w_rpen_next;

    // The penalised player restarts one step closer to losing.
    always_comb begin
        w_restart_pos = 3'd3;
        if (r_lpen && !r_rpen)
            w_restart_pos = 3'd4;
        else if (r_rpen && !r_lpen)
            w_restart_pos = 3'd2;
    end
`else
    assign w_restart_pos = 3'd3;
`endif

    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        w_state_next  = r_state;
        w_pos_next    = r_pos;
        w_lcount_next = r_lcount;
        w_rcount_next = r_rcount;
        w_hold_next   = r_hold;
`ifdef FALSE_START_EN
        w_lpen_next   = r_lpen;
        w_rpen_next   = r_rpen;
`endif
        case (r_state)
            PLAY: begin
                if (bus.lpush && !bus.rpush && r_pos != 3'd0)
                    w_pos_next = r_pos - 3'd1;
                else if (bus.rpush && !bus.lpush && r_pos != 3'd6)
                    w_pos_next = r_pos + 3'd1;

                if (w_pos_next == 3'd0) begin
                    w_lcount_next = sat_inc(r_lcount);
                    w_state_next  = (w_lcount_next == WIN_C) ? OVER : HOLD;
                end else if (w_pos_next == 3'd6) begin
                    w_rcount_next = sat_inc(r_rcount);
                    w_state_next  = (w_rcount_next == WIN_C) ? OVER : HOLD;
                end
            end
            HOLD: begin
`ifdef FALSE_START_EN
                w_lpen_next = r_lpen | bus.lpush;
                w_rpen_next = r_rpen | bus.rpush;
`endif
                // The release edge ignores its own pushes; only earlier flags count.
                if (bus.slowen) begin
                    if (r_hold + 4'd1 == HOLD_C) begin
                        w_pos_next   = w_restart_pos;
                        w_hold_next  = 4'd0;
                        w_state_next = PLAY;
`ifdef FALSE_START_EN
                        w_lpen_next  = 1'b0;
                        w_rpen_next  = 1'b0;
`endif
                    end else begin
                        w_hold_next = r_hold + 4'd1;
                    end
                end
            end
            OVER:    ;
            default: w_state_next = PLAY;
        endcase
    end

    // Outputs are decoded from next-state values so the registered copies track the state.
    always_comb begin
        w_rope_led = 7'd1 << w_pos_next;
        w_score    = {therm(w_rcount_next), 1'b0, therm(w_lcount_next)};
        w_victory  = (w_state_next == OVER);
        w_winner   = w_victory && (w_rcount_next == WIN_C);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= PLAY;
            r_pos      <= 3'd3;
            r_lcount   <= 2'd0;
            r_rcount   <= 2'd0;
            r_hold     <= 4'd0;
            r_rope_led <= 7'b0001000;
            r_score    <= 7'b0000000;
            r_victory  <= 1'b0;
            r_winner   <= 1'b0;
`ifdef FALSE_START_EN
            r_lpen     <= 1'b0;
            r_rpen     <= 1'b0;
`endif
        end else begin
            r_state    <= w_state_next;
            r_pos      <= w_pos_next;
            r_lcount   <= w_lcount_next;
            r_rcount   <= w_rcount_next;
            r_hold     <= w_hold_next;
            r_rope_led <= w_rope_led;
            r_score    <= w_score;
            r_victory  <= w_victory;
            r_winner   <= w_winner;
`ifdef FALSE_START_EN
            r_lpen     <= w_lpen_next;
            r_rpen     <= w_rpen_next;
`endif
        end
    end

    assign bus.rope_led  = r_rope_led;
    assign bus.score     = r_score;
    assign bus.isVictory = r_victory;
    assign bus.winner    = r_winner;

endmodule

// File: tb/tb_tug_referee.sv
// Directed bench for tug_referee (WIN_ROUNDS=3, ROUND_HOLD=4); honours FALSE_START_EN if defined.
module tb_tug_referee;

    logic clk = 1'b0;
    logic rst;
    int   vectors    = 0;
    int   miscompares = 0;
    int   pos_e;

    tug_referee_if bus();

    tug_referee #(.WIN_ROUNDS(3), .ROUND_HOLD(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] onehot(input int p);
        return 7'd1 << p;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic pulse_l();
        bus.lpush = 1'b1;
        tick();
        bus.lpush = 1'b0;
    endtask

    task automatic pulse_r();
        bus.rpush = 1'b1;
        tick();
        bus.rpush = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            bus.slowen = 1'b1;
            tick();
            bus.slowen = 1'b0;
            tick();
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_rope"}, bus.rope_led, 7'b0001000);
        check({tag, "_score"}, bus.score, 7'b0000000);
        check({tag, "_vw"}, {5'd0, bus.isVictory, bus.winner}, 7'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.lpush = 1'b1;
        bus.rpush = 1'b1;
        bus.slowen = 1'b1;
        tick();
        rst = 1'b0;
        bus.lpush = 1'b0;
        bus.rpush = 1'b0;
        bus.slowen = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        bus.lpush = 1'b1;
        bus.rpush = 1'b0;
        bus.slowen = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        bus.lpush = 1'b0;
        bus.slowen = 1'b0;
        check_reset("reset");

        // Round 1: left pulls three times, spaced two cycles.
        pulse_l(); check("l1_rope", bus.rope_led, 7'b0000100); tick();
        pulse_l(); check("l2_rope", bus.rope_led, 7'b0000010); tick();
        pulse_l(); check("l3_rope", bus.rope_led, 7'b0000001);
        check("l3_score", bus.score, 7'b0000001);
        check("l3_vw", {5'd0, bus.isVictory, bus.winner}, 7'd0);

        // Hold: pushes frozen, three ticks keep it frozen, fourth releases.
        pulse_r(); check("hold_rpush", bus.rope_led, 7'b0000001);
        ticks(3);  check("hold_3ticks", bus.rope_led, 7'b0000001);
        bus.slowen = 1'b1;
        bus.lpush  = 1'b1;
        tick();
        bus.slowen = 1'b0;
        bus.lpush  = 1'b0;
`ifdef FALSE_START_EN
        pos_e = 2;
`else
        pos_e = 3;
`endif
        check("release1", bus.rope_led, onehot(pos_e));

        // Both pushes together: no movement; then a single push moves at once.
        bus.lpush = 1'b1;
        bus.rpush = 1'b1;
        tick();
        bus.lpush = 1'b0;
        bus.rpush = 1'b0;
        check("both_push", bus.rope_led, onehot(pos_e));
        pulse_l(); pos_e--;
        check("first_push", bus.rope_led, onehot(pos_e));

        // Round 2 to the left end.
        while (pos_e > 0) begin
            pulse_l(); pos_e--;
            check("r2_rope", bus.rope_led, onehot(pos_e));
        end
        check("r2_score", bus.score, 7'b0000011);

        // False start by left during hold.
        pulse_l(); check("hold2_lpush", bus.rope_led, 7'b0000001);
        ticks(4);
`ifdef FALSE_START_EN
        pos_e = 4;
`else
        pos_e = 3;
`endif
        check("release2", bus.rope_led, onehot(pos_e));

        // Round 3 decides the game for left.
        while (pos_e > 0) begin
            pulse_l(); pos_e--;
        end
        check("win_l_rope", bus.rope_led, 7'b0000001);
        check("win_l_score", bus.score, 7'b0000111);
        check("win_l_vw", {5'd0, bus.isVictory, bus.winner}, 7'b0000010);

        // Game over: pushes and ticks change nothing.
        pulse_r(); pulse_r(); ticks(5); pulse_l();
        check("over_rope", bus.rope_led, 7'b0000001);
        check("over_score", bus.score, 7'b0000111);
        check("over_vw", {5'd0, bus.isVictory, bus.winner}, 7'b0000010);

        do_reset();
        check_reset("over_rst");

        // Right takes two rounds, then reset lands mid-hold.
        pulse_r(); check("r1_rope", bus.rope_led, 7'b0010000);
        pulse_r(); pulse_r();
        check("r1_end", bus.rope_led, 7'b1000000);
        check("r1_score", bus.score, 7'b0010000);
        ticks(4);  check("r1_release", bus.rope_led, 7'b0001000);
        repeat (3) pulse_r();
        check("r2_score_r", bus.score, 7'b0110000);
        ticks(2);
        do_reset();
        check_reset("midhold_rst");
        pulse_l(); check("post_rst_play", bus.rope_led, 7'b0000100);

        // Right wins the whole game.
        do_reset();
        for (int r = 0; r < 2; r++) begin
            repeat (3) pulse_r();
            ticks(4);
        end
        check("r_pre_win", bus.rope_led, 7'b0001000);
        repeat (3) pulse_r();
        check("win_r_score", bus.score, 7'b1110000);
        check("win_r_vw", {5'd0, bus.isVictory, bus.winner}, 7'b0000011);
        pulse_l(); check("win_r_frozen", bus.rope_led, 7'b1000000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/tug_referee.md
TUG_REFEREE -- requirements
Module: tug_referee

Interface
REQ-001 Parameter WIN_ROUNDS, default 3, rounds a player needs to win the game; legal range 1..3.
REQ-002 Parameter ROUND_HOLD, default 4, slowen ticks the rope is frozen after a round is decided; legal range 1..15.
REQ-003 clk  input  1  system clock; single clock domain, all state updates on rising edge.
REQ-004 rst  input  1  reset; one clock; reset is synchronous and active-high.
REQ-005 lpush  input  1  left-player pull, one-cycle pulse, already synchronised and one-shot upstream.
REQ-006 rpush  input  1  right-player pull, one-cycle pulse, already synchronised and one-shot upstream.
REQ-007 slowen  input  1  one-cycle slow enable tick, used only for round-hold timing.
REQ-008 rope_led  output  7  one-hot rope marker; bit n set when position == n.
REQ-009 score  output  7  {right thermometer[2:0], 1'b0, left thermometer[2:0]}; feeds the victory-cheer stage.
REQ-010 isVictory  output  1  level, high once either player reaches WIN_ROUNDS; held until rst.
REQ-011 winner  output  1  0 = left won game, 1 = right won game; valid while isVictory=1, else 0.

Function
REQ-012 Rope position pos is a 3-bit register, range 0..6, centre 3; pos 0 = left end, pos 6 = right end.
REQ-013 The block SHALL implement states PLAY, HOLD, OVER; all outputs registered.
REQ-014 In PLAY: lpush alone -> pos-1; rpush alone -> pos+1; both or neither -> pos unchanged.
REQ-015 Latency: a push pulse in cycle N is reflected in rope_led after the edge ending cycle N (one cycle).
REQ-016 On the edge where pos becomes 0: lcount += 1; on the edge where pos becomes 6: rcount += 1; same edge enters HOLD, or OVER if the new count == WIN_ROUNDS.
REQ-017 Round counters are 2-bit, saturate at WIN_ROUNDS, never wrap.
REQ-018 score thermometer for count k SHALL have the low k bits of the 3-bit field set (0->000, 1->001, 2->011, 3->111); score[3] always 0.
REQ-019 In HOLD: pos frozen at the end reached; pushes do not move the rope; 4-bit hold counter increments on each slowen pulse.
REQ-020 When the hold counter reaches ROUND_HOLD: pos <= start position (REQ-028), hold counter <= 0, state <= PLAY on that edge.
REQ-021 A push coincident with the HOLD->PLAY edge SHALL be ignored; the first acceptable push is one cycle after entering PLAY.
REQ-022 slowen pulses in PLAY or OVER SHALL have no effect.
REQ-023 In OVER: pos, counts, rope_led, score frozen; isVictory=1; winner = side whose count reached WIN_ROUNDS; all pushes ignored.

Reset
REQ-024 rst high at a rising edge SHALL force: state PLAY, pos 3 (rope_led 7'b0001000), lcount 0, rcount 0, score 7'b0000000, isVictory 0, winner 0, hold counter 0, penalty flags 0.
REQ-025 rst SHALL take priority over any simultaneous push, slowen or state transition, including mid-HOLD and in OVER.
REQ-026 Push pulses in the rst cycle are discarded, not queued.

Configuration
REQ-027 Macro FALSE_START_EN compiles in the false-start penalty; without it all pushes in HOLD are ignored and restart position is always 3.
REQ-028 With FALSE_START_EN: lpush during HOLD sets lpen, rpush during HOLD sets rpen; restart pos = 4 if only lpen, 2 if only rpen, 3 if both or neither; both flags clear on the HOLD->PLAY edge.

Verification
REQ-029 Reset, then 3 lpush pulses spaced 2 cycles -> rope_led 0001000 -> 0000100 -> 0000010 -> 0000001, score 0000001, state HOLD.
REQ-030 In HOLD with ROUND_HOLD=4, pulse slowen 4 times -> rope_led returns to 0001000 on the edge after the 4th tick; pushes during hold leave rope_led unchanged.
REQ-031 lpush and rpush asserted in the same cycle in PLAY from pos 3 -> rope_led stays 0001000.
REQ-032 Left wins 3 rounds -> score 0000111, isVictory 1, winner 0; further rpush pulses -> no output change; rst -> all outputs to reset values.
REQ-033 FALSE_START_EN defined: lpush during HOLD -> next round starts with rope_led 0010000; undefined: same stimulus -> 0001000.
REQ-034 rst asserted mid-HOLD after right has 2 rounds -> score 0000000, rope_led 0001000, state PLAY next cycle.
